countdown_timer: RTL

- BCD countdown timer (MM:SS:cc, 10 ms resolution). It counts down from a preset and raises an alarm at 00:00:00.
- It is the counting-down counterpart of the stopwatch and targets the same DE1-SOC board setup (50 MHz clock, six 7-seg digits).
- Control inputs are single-cycle pulses from the board key debouncers. Digit outputs feed the existing sevenseg decoders at top level.

---
 rtl/countdown_timer_pkg.sv | 38 +++
 rtl/countdown_timer_if.sv | 26 ++
 rtl/countdown_tick_gen.sv | 26 ++
 rtl/countdown_timer.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared types, BCD digit limits and digit helpers for the MM:SS:cc countdown timer.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] DIGIT_MAX  = 4'd9;
  localparam logic [3:0] SEC_HI_MAX = 4'd5;

  typedef struct packed {
    logic [3:0] min_hi;
    logic [3:0] min_lo;
    logic [3:0] sec_hi;
    logic [3:0] sec_lo;
    logic [3:0] cs_hi;
    logic [3:0] cs_lo;
  } bcd_time_t;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max);
    return (d > max) ? max : d;
  endfunction

  // Returns {borrow_out, digit}: decrement only when a borrow arrives, wrapping 0 to max.
  function automatic logic [4:0] bcd_dec(input logic [3:0] d, input logic [3:0] max,
                                         input logic borrow_in);
    if (!borrow_in)
      return {1'b0, d};
    else if (d == 4'd0)
      return {1'b1, max};
    else
      return {1'b0, d - 4'd1};
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control pulses, presets and display/status outputs of the countdown timer.
interface countdown_timer_if;
  logic       load_pulse;
  logic       start_pause_pulse;
  logic       hold_pulse;
  logic [7:0] preset_min;
  logic [7:0] preset_sec;
  logic [3:0] dig5;
  logic [3:0] dig4;
  logic [3:0] dig3;
  logic [3:0] dig2;
  logic [3:0] dig1;
  logic [3:0] dig0;
  logic       running;
  logic       alarm;

  modport master (
    output load_pulse, start_pause_pulse, hold_pulse, preset_min, preset_sec,
    input  dig5, dig4, dig3, dig2, dig1, dig0, running, alarm
  );

  modport slave (
    input  load_pulse, start_pause_pulse, hold_pulse, preset_min, preset_sec,
    output dig5, dig4, dig3, dig2, dig1, dig0, running, alarm
  );
endinterface

// File: rtl/countdown_tick_gen.sv
// 10 ms tick divider: counts while enabled, tick on the last count, synchronous clear.
module countdown_tick_gen #(
  parameter int unsigned TICK_DIV = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic tick
);
  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] div;

  assign tick = en && (div == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      div <= '0;
    else if (clear)
      div <= '0;
    else if (en)
      div <= tick ? '0 : div + 1'b1;
  end
endmodule

// File: rtl/countdown_timer.sv
// BCD countdown timer MM:SS:cc with alarm at zero and display freeze.
// Optional COUNTDOWN_ALARM_BLINK_EN makes the alarm blink while in DONE.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 500000,
  parameter int unsigned BLINK_TICKS = 25
) (
  input  logic             clk,
  input  logic             key_reset,
  countdown_timer_if.slave bus
);
  state_t    state, next_state;
  bcd_time_t count, next_count, count_dec, preset_val, disp;
  logic [4:0] borrow;
  logic      tick, div_en, div_clear, load_ok, count_zero, dec_zero;
  logic      freeze, running_q, alarm_q;

`ifdef COUNTDOWN_ALARM_BLINK_EN
  assign div_en = (state == RUN) || (state == DONE);
`else
  assign div_en = (state == RUN);
`endif

  countdown_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (key_reset),
    .en   (div_en),
    .clear(div_clear),
    .tick (tick)
  );

  always_comb begin
    preset_val        = '0;
    preset_val.min_hi = clamp_digit(bus.preset_min[7:4], DIGIT_MAX);
    preset_val.min_lo = clamp_digit(bus.preset_min[3:0], DIGIT_MAX);
    preset_val.sec_hi = clamp_digit(bus.preset_sec[7:4], SEC_HI_MAX);
    preset_val.sec_lo = clamp_digit(bus.preset_sec[3:0], DIGIT_MAX);
  end

  // Borrow ripples from centiseconds up to min_hi; seconds tens wrap to 5.
  always_comb begin
    count_dec = count;
    borrow    = '0;
    {borrow[0], count_dec.cs_lo}  = bcd_dec(count.cs_lo,  DIGIT_MAX,  1'b1);
    {borrow[1], count_dec.cs_hi}  = bcd_dec(count.cs_hi,  DIGIT_MAX,  borrow[0]);
    {borrow[2], count_dec.sec_lo} = bcd_dec(count.sec_lo, DIGIT_MAX,  borrow[1]);
    {borrow[3], count_dec.sec_hi} = bcd_dec(count.sec_hi, SEC_HI_MAX, borrow[2]);
    {borrow[4], count_dec.min_lo} = bcd_dec(count.min_lo, DIGIT_MAX,  borrow[3]);
    count_dec.min_hi = borrow[4] ? count.min_hi - 4'd1 : count.min_hi;
  end

  assign count_zero = (count == '0);
  assign dec_zero   = (count_dec == '0);
  assign load_ok    = bus.load_pulse && (state != RUN);

  always_comb begin
    next_state = state;
    next_count = count;
    div_clear  = 1'b0;
    if (load_ok) begin
      next_state = IDLE;
      next_count = preset_val;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start_pause_pulse && !count_zero) begin
            next_state = RUN;
            div_clear  = 1'b1;
          end
        end
        RUN: begin
          if (tick) begin
            next_count = count_dec;
            if (dec_zero)
              next_state = DONE;
          end
          // Reaching zero on the same edge as a pause request still ends in DONE.
          if (bus.start_pause_pulse && !(tick && dec_zero))
            next_state = PAUSE;
        end
        PAUSE: begin
          if (bus.start_pause_pulse)
            next_state = RUN;
        end
        DONE: begin
          if (bus.start_pause_pulse)
            next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge key_reset) begin
    if (key_reset) begin
      state     <= IDLE;
      count     <= '0;
      disp      <= '0;
      running_q <= 1'b0;
      freeze    <= 1'b0;
    end else begin
      state     <= next_state;
      count     <= next_count;
      running_q <= (next_state == RUN);
      if (bus.hold_pulse)
        freeze <= ~freeze;
      if (!freeze)
        disp <= count;
    end
  end

`ifdef COUNTDOWN_ALARM_BLINK_EN
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  logic [BW-1:0] blink_cnt;

  // Alarm starts high on DONE entry and toggles every BLINK_TICKS ticks while there.
  always_ff @(posedge clk or posedge key_reset) begin
    if (key_reset) begin
      alarm_q   <= 1'b0;
      blink_cnt <= '0;
    end else if (next_state != DONE) begin
      alarm_q   <= 1'b0;
      blink_cnt <= '0;
    end else if (state != DONE) begin
      alarm_q   <= 1'b1;
      blink_cnt <= '0;
    end else if (tick) begin
      if (blink_cnt == BLINK_LAST) begin
        alarm_q   <= ~alarm_q;
        blink_cnt <= '0;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end
`else
  always_ff @(posedge clk or posedge key_reset) begin
    if (key_reset)
      alarm_q <= 1'b0;
    else
      alarm_q <= (next_state == DONE);
  end
`endif

  assign bus.dig5    = disp.min_hi;
  assign bus.dig4    = disp.min_lo;
  assign bus.dig3    = disp.sec_hi;
  assign bus.dig2    = disp.sec_lo;
  assign bus.dig1    = disp.cs_hi;
  assign bus.dig0    = disp.cs_lo;
  assign bus.running = running_q;
  assign bus.alarm   = alarm_q;
endmodule
